// File: rtl/hazard_stall_ctrl_pkg.sv
// Shared constants and types for the pipeline hazard / stall controller.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package hazard_stall_ctrl_pkg;

  // Register-file address length used across the core.
  localparam int REGFILE_ADDR_LEN = 4;

  // Default source/destination register-address width seen by the hazard unit.
  localparam int DEFAULT_REG_ADDR_W = REGFILE_ADDR_LEN;

  // Memory-wait supervisor states.
  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_FAULT    = 2'd2
  } fsm_state_e;

  // Width of a forwarding select covering "register file" plus one code per stage.
  function automatic int fwd_sel_width(input int num_stages);
    return (num_stages < 1) ? 1 : $clog2(num_stages + 1);
  endfunction

endpackage

// File: rtl/hazard_stall_ctrl_stage_match.sv
// Compares one ID source against every downstream producer and picks the youngest.
// Latency: purely combinational, zero cycles.
// Backpressure: none; evaluated every cycle from the current pipeline view.
module stage_match
  import hazard_stall_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W = DEFAULT_REG_ADDR_W,
  parameter int NUM_STAGES = 2,
  parameter int SEL_W      = fwd_sel_width(NUM_STAGES)
) (
  input  logic                             src_used,
  input  logic [REG_ADDR_W-1:0]            src,
  input  logic [NUM_STAGES*REG_ADDR_W-1:0] dest_vec,
  input  logic [NUM_STAGES-1:0]            wb_en_vec,
  output logic [NUM_STAGES-1:0]            match,
  output logic [SEL_W-1:0]                 sel
);

  // Per-stage match; register 0 is treated like any other register.
  always_comb begin
    match = '0;
    for (int k = 0; k < NUM_STAGES; k++) begin
      match[k] = src_used & wb_en_vec[k] &
                 (dest_vec[k*REG_ADDR_W +: REG_ADDR_W] == src);
    end
  end

  // Priority select: scanning oldest to youngest lets the lowest index win.
  always_comb begin
    sel = '0;
    for (int k = NUM_STAGES - 1; k >= 0; k--) begin
      if (match[k]) begin
        sel = SEL_W'(k + 1);
      end
    end
  end

endmodule

// File: rtl/hazard_stall_ctrl.sv
// RAW hazard detection, forwarding select, memory-wait freeze and stall statistics.
// Latency: stall/freeze/selects are combinational; stall_count and mem_timeout update next edge.
// Backpressure: mem_ready low freezes the whole pipe and overrides any bubble request.
module hazard_stall_ctrl
  import hazard_stall_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W = DEFAULT_REG_ADDR_W,
  parameter int NUM_STAGES = 2,
  parameter int CNT_W      = 16,
  parameter int TIMEOUT    = 255
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               two_src,
  input  logic [REG_ADDR_W-1:0]              src1,
  input  logic [REG_ADDR_W-1:0]              src2,
  input  logic [NUM_STAGES*REG_ADDR_W-1:0]   dest_vec,
  input  logic [NUM_STAGES-1:0]              wb_en_vec,
  input  logic                               exe_mem_read,
  input  logic                               fwd_en,
  input  logic                               mem_ready,
  input  logic                               cnt_clr,
  output logic                               hazard_stall,
  output logic                               pipe_freeze,
  output logic [$clog2(NUM_STAGES+1)-1:0]    sel_src1,
  output logic [$clog2(NUM_STAGES+1)-1:0]    sel_src2,
  output logic [CNT_W-1:0]                   stall_count,
  output logic                               mem_timeout
);

  localparam int SEL_W  = $clog2(NUM_STAGES + 1);
  // Wait counter must be able to hold TIMEOUT itself, since it parks there in FAULT.
  localparam int WAIT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

  logic [NUM_STAGES-1:0] match1;
  logic [NUM_STAGES-1:0] match2;
  logic [SEL_W-1:0]      sel1_raw;
  logic [SEL_W-1:0]      sel2_raw;
  logic                  raw_hazard;

  fsm_state_e        state_q,       state_d;
  logic [WAIT_W-1:0] wait_cnt_q,    wait_cnt_d;
  logic              mem_timeout_q, mem_timeout_d;
  logic [CNT_W-1:0]  stall_cnt_q,   stall_cnt_d;

  stage_match #(
    .REG_ADDR_W (REG_ADDR_W),
    .NUM_STAGES (NUM_STAGES),
    .SEL_W      (SEL_W)
  ) u_match_src1 (
    .src_used  (1'b1),
    .src       (src1),
    .dest_vec  (dest_vec),
    .wb_en_vec (wb_en_vec),
    .match     (match1),
    .sel       (sel1_raw)
  );

  stage_match #(
    .REG_ADDR_W (REG_ADDR_W),
    .NUM_STAGES (NUM_STAGES),
    .SEL_W      (SEL_W)
  ) u_match_src2 (
    .src_used  (two_src),
    .src       (src2),
    .dest_vec  (dest_vec),
    .wb_en_vec (wb_en_vec),
    .match     (match2),
    .sel       (sel2_raw)
  );

  // Hazard/freeze decode: with forwarding only an EXE load can't be bypassed.
  always_comb begin
    if (fwd_en) begin
      raw_hazard = exe_mem_read & (match1[0] | match2[0]);
      sel_src1   = sel1_raw;
      sel_src2   = sel2_raw;
    end else begin
      raw_hazard = (|match1) | (|match2);
      sel_src1   = '0;
      sel_src2   = '0;
    end
    pipe_freeze  = ~mem_ready;
    hazard_stall = raw_hazard & ~pipe_freeze;
  end

  // Memory-wait supervisor next state: count wait cycles, trip a sticky fault.
  always_comb begin
    state_d       = state_q;
    wait_cnt_d    = wait_cnt_q;
    mem_timeout_d = mem_timeout_q;
    case (state_q)
      ST_IDLE: begin
        if (!mem_ready) begin
          state_d    = ST_MEM_WAIT;
          wait_cnt_d = '0;
        end
      end
      ST_MEM_WAIT: begin
        if (mem_ready) begin
          state_d = ST_IDLE;
        end else begin
          wait_cnt_d = wait_cnt_q + WAIT_W'(1);
          if (wait_cnt_q == WAIT_W'(TIMEOUT - 1)) begin
            state_d       = ST_FAULT;
            mem_timeout_d = 1'b1;
          end
        end
      end
      ST_FAULT: begin
        if (mem_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Supervisor state, wait counter and fault flag registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      wait_cnt_q    <= '0;
      mem_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      mem_timeout_q <= mem_timeout_d;
    end
  end

  // Stall statistics: clear beats increment, count saturates at all-ones.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (cnt_clr) begin
      stall_cnt_d = '0;
    end else if ((hazard_stall | pipe_freeze) && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  // Stall counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_count = stall_cnt_q;
  assign mem_timeout = mem_timeout_q;

endmodule

// File: doc/hazard_stall_ctrl.md
HAZARD_STALL_CTRL -- requirements
Module: hazard_stall_ctrl

Interface
REQ-001 SHALL have parameter REG_ADDR_W, default 4, register-address width.
REQ-002 SHALL have parameter NUM_STAGES, default 2, number of downstream producer stages checked; index 0 = EXE, 1 = MEM, higher = later.
REQ-003 SHALL have parameter CNT_W, default 16, stall-counter width.
REQ-004 SHALL have parameter TIMEOUT, default 255, maximum memory-wait cycles before fault.
REQ-005 Clock and reset are decided: one clock `clk`, rising edge; reset `rst` is asynchronous and active-high.
REQ-006 Ports, as name  direction  width  meaning:
- clk  in  1  clock.
- rst  in  1  async active-high reset.
- two_src  in  1  ID instruction reads src2.
- src1  in  REG_ADDR_W  ID source Rn.
- src2  in  REG_ADDR_W  ID source Rm/Rd.
- dest_vec  in  NUM_STAGES*REG_ADDR_W  stage k destination at bits [k*REG_ADDR_W +: REG_ADDR_W].
- wb_en_vec  in  NUM_STAGES  stage k writes back.
- exe_mem_read  in  1  EXE instruction is a load.
- fwd_en  in  1  forwarding mode enable.
- mem_ready  in  1  memory stage access complete.
- cnt_clr  in  1  synchronous clear of stall_count.
- hazard_stall  out  1  freeze PC and IF/ID, bubble ID/EX.
- pipe_freeze  out  1  freeze all pipeline registers.
- sel_src1  out  $clog2(NUM_STAGES+1)  forwarding select; 0 = register file, k+1 = stage k.
- sel_src2  out  $clog2(NUM_STAGES+1)  same as sel_src1, for src2.
- stall_count  out  CNT_W  saturating count of stall cycles.
- mem_timeout  out  1  sticky memory-wait fault.

Function
REQ-007 match1[k] SHALL be wb_en_vec[k] & (dest k == src1); match2[k] SHALL be wb_en_vec[k] & two_src & (dest k == src2); register 0 is not exempt.
REQ-008 With fwd_en=0, raw_hazard SHALL be the OR of all match1 and match2 bits.
REQ-009 With fwd_en=1, raw_hazard SHALL be exe_mem_read & (match1[0] | match2[0]) only, i.e. load-use.
REQ-010 With fwd_en=1, sel_srcN SHALL be k+1 for the lowest k with matchN[k], else 0; the youngest producer wins.
REQ-011 With fwd_en=0, sel_src1 and sel_src2 SHALL be 0.
REQ-012 The FSM SHALL have states IDLE, MEM_WAIT, FAULT.
- IDLE→MEM_WAIT on mem_ready=0.
- MEM_WAIT→IDLE on mem_ready=1.
- MEM_WAIT→FAULT when the wait counter reaches TIMEOUT with mem_ready still 0.
- FAULT→IDLE on mem_ready=1.
REQ-013 pipe_freeze SHALL be combinational: ~mem_ready in any state; it does not depend on registered state.
REQ-014 hazard_stall SHALL be raw_hazard & ~pipe_freeze; freeze has priority, so no bubble is inserted while frozen.
REQ-015 The wait counter SHALL clear on entry to MEM_WAIT, increment each MEM_WAIT cycle, and hold in FAULT.
REQ-016 mem_timeout SHALL set on the MEM_WAIT→FAULT transition and clear only on reset.
REQ-017 stall_count SHALL increment each cycle hazard_stall | pipe_freeze is 1 and SHALL saturate at all-ones.
REQ-018 If cnt_clr and an increment occur in the same cycle, clear SHALL win, giving 0 next cycle.
REQ-019 hazard_stall, pipe_freeze and sel_src* SHALL have zero-cycle latency; stall_count and mem_timeout SHALL update at the next edge.

Reset
REQ-020 On rst=1 the block SHALL asynchronously force state=IDLE, wait counter=0, stall_count=0 and mem_timeout=0.
REQ-021 Reset asserted mid-MEM_WAIT or in FAULT SHALL return the FSM to IDLE with no residual timeout.
REQ-022 Combinational outputs SHALL follow their inputs during reset.

Structure
REQ-023 The FSM state encoding and the default REG_ADDR_W SHALL live in the shared constants package, alongside the existing register-file address length.
REQ-024 A sub-module stage_match SHALL compute match1/match2 and the priority forwarding select for one source; it SHALL be instantiated twice.

Verification
REQ-025 Scenario 1: fwd_en=0, src1=3, dest0=3, wb_en0=1 -> hazard_stall=1, sel_src1=0.
REQ-026 Scenario 2: fwd_en=1, src2=5, two_src=1, dest0=5, dest1=5, both wb_en, exe_mem_read=0 -> hazard_stall=0, sel_src2=1.
REQ-027 Scenario 3: fwd_en=1, src1=7, dest0=7, exe_mem_read=1 -> hazard_stall=1 for that cycle; after load moves to MEM (dest1=7, dest0 unrelated) -> hazard_stall=0, sel_src1=2.
REQ-028 Scenario 4: two_src=0, src2=dest1=4, wb_en1=1, fwd_en=0, no src1 match -> hazard_stall=0.
REQ-029 Scenario 5: TIMEOUT=3, mem_ready=0 held 5 cycles -> pipe_freeze=1 throughout; mem_timeout=1 after the 4th edge; stall_count=5; hazard_stall=0 despite a matching source.
REQ-030 Scenario 6: stall_count at all-ones with a continuing stall -> holds; cnt_clr with a stall -> 0; rst pulse in FAULT -> IDLE, mem_timeout=0.
